// File: rtl/uart_frame_receiver.sv
// 8N1 serial receiver: two-flop synchronizer, mid-bit sampling FSM and a
// ready/valid holding register with framing-error and overrun pulses.
module uart_frame_receiver #(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   output logic       framing_error,
   output logic       overrun
);

   localparam int unsigned N  = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned H  = N / 2;
   localparam int unsigned CW = $clog2(N);

   localparam logic [CW-1:0] CntHalf = CW'(H - 1);
   localparam logic [CW-1:0] CntFull = CW'(N - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } state_e;

   logic          sync_q;
   logic          rx_s_q;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          commit_q, commit_d;
   logic          ferr_q, ferr_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          fe_out_q, fe_out_d;
   logic          ovr_q, ovr_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      commit_d  = 1'b0;
      ferr_d    = 1'b0;

      case (state_q)
         StIdle: begin
            if (!rx_s_q) begin
               state_d = StStart;
               cnt_d   = '0;
            end
         end
         StStart: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntHalf) begin
               if (rx_s_q) begin
                  state_d = StIdle;
               end else begin
                  state_d   = StData;
                  cnt_d     = '0;
                  bit_idx_d = '0;
               end
            end
         end
         StData: begin
            if (cnt_q == CntFull) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (cnt_q == CntFull) begin
               cnt_d = '0;
               // Leave mid stop bit so a start edge in its second half is caught
               if (rx_s_q) begin
                  state_d  = StIdle;
                  commit_d = 1'b1;
               end else begin
                  state_d = StBreak;
                  ferr_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StBreak: begin
            if (rx_s_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A pending commit wins over a same-cycle handshake clear
   always_comb begin
      data_d   = data_q;
      valid_d  = valid_q;
      ovr_d    = 1'b0;
      fe_out_d = ferr_q;
      if (commit_q) begin
         if (!valid_q || data_out_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && data_out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         commit_q  <= 1'b0;
         ferr_q    <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         fe_out_q  <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         sync_q    <= serial_in;
         rx_s_q    <= sync_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         commit_q  <= commit_d;
         ferr_q    <= ferr_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         fe_out_q  <= fe_out_d;
         ovr_q     <= ovr_d;
      end
   end

   assign data_out       = data_q;
   assign data_out_valid = valid_q;
   assign framing_error  = fe_out_q;
   assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Bench for uart_frame_receiver at N=10: vector table, corner sequences and
// random frames, all checked every cycle against a frame-level timing model.
module tb_uart_frame_receiver;

   localparam int CF = 1_000_000;
   localparam int BR = 100_000;
   localparam int N  = CF / BR;
   localparam int H  = N / 2;
   localparam int COMMIT_OFS = 4 + H + 9 * N;

   logic       clk;
   logic       rst;
   logic       serial_in;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready;
   logic       framing_error;
   logic       overrun;

   uart_frame_receiver #(
      .CLOCK_FREQ(CF),
      .BAUD_RATE (BR)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .serial_in     (serial_in),
      .data_out      (data_out),
      .data_out_valid(data_out_valid),
      .data_out_ready(data_out_ready),
      .framing_error (framing_error),
      .overrun       (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       rdy;
      int         gap;
      logic       drain;
      logic [7:0] e_data;
      logic       e_valid;
      logic       e_fe;
      logic       e_ovr;
   } vec_t;

   vec_t tbl [8];

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   fe_count = 0;
   int   f0;
   int   ce_hs;
   bit   done;
   bit   mon_en;
   bit   rdone;
   logic [9:0] ab_fr;
   logic [7:0] rnd_d;
   logic       rnd_stop;
   int         rnd_gap;

   // Frame-level expectations keyed by the clock edge at which they take effect
   logic [7:0] commit_at [int];
   bit         ferr_at [int];

   logic [7:0] exp_data;
   logic       exp_valid;
   logic       exp_fe;
   logic       exp_ovr;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      exp_fe  <= 1'b0;
      exp_ovr <= 1'b0;
      if (rst) begin
         exp_data  <= 8'h00;
         exp_valid <= 1'b0;
      end else begin
         if (commit_at.exists(cyc + 1)) begin
            if (!exp_valid || data_out_ready) begin
               exp_data  <= commit_at[cyc + 1];
               exp_valid <= 1'b1;
            end else begin
               exp_ovr <= 1'b1;
            end
         end else if (exp_valid && data_out_ready) begin
            exp_valid <= 1'b0;
         end
         if (ferr_at.exists(cyc + 1)) exp_fe <= 1'b1;
      end
   end

   task automatic chk(input string nm, input logic [7:0] ed, input logic ev, input logic efe,
                      input logic eov);
      checks++;
      if ({data_out_valid, data_out, framing_error, overrun} !== {ev, ed, efe, eov}) begin
         errors++;
         $display("FAIL %s: got valid=%b data=%h fe=%b ovr=%b, expected valid=%b data=%h fe=%b ovr=%b",
                  nm, data_out_valid, data_out, framing_error, overrun, ev, ed, efe, eov);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   // Called #1 after a rising edge; the next edge is cycle 0 of the frame
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic track);
      logic [9:0] fr;
      int         ce;
      fr = {stop, d, 1'b0};
      ce = cyc + COMMIT_OFS;
      if (track) begin
         if (stop) commit_at[ce] = d;
         else ferr_at[ce] = 1'b1;
      end
      for (int b = 0; b < 10; b++) begin
         serial_in = fr[b];
         repeat (N) @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_edge(input int e, input string nm);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (cyc == e) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout waiting for edge %0d, now at %0d", nm, e, cyc);
      end
   endtask

   task automatic run_frame(input string nm, input logic [7:0] d, input logic stop,
                            input logic [7:0] ed, input logic ev, input logic efe,
                            input logic eov);
      int ce;
      ce = cyc + COMMIT_OFS;
      fork
         send_frame(d, stop, 1'b1);
         begin
            wait_edge(ce, nm);
            chk(nm, ed, ev, efe, eov);
         end
      join
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst            = 1'b1;
      serial_in      = 1'b1;
      data_out_ready = 1'b0;
      done           = 1'b0;
      mon_en         = 1'b0;
      rdone          = 1'b0;

      tbl[0] = '{8'hA5, 1'b1, 1'b0, 2,  1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{8'h3C, 1'b0, 1'b0, 20, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{8'h55, 1'b1, 1'b0, 2,  1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{8'h11, 1'b1, 1'b0, 2,  1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{8'h22, 1'b1, 1'b0, 2,  1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{8'h00, 1'b1, 1'b1, 0,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{8'hFF, 1'b1, 1'b1, 0,  1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{8'h80, 1'b1, 1'b1, 2,  1'b0, 8'h80, 1'b1, 1'b0, 1'b0};

      fork
         begin
            while (!done) begin
               @(negedge clk);
               if (mon_en) begin
                  chk($sformatf("cycle %0d", cyc), exp_data, exp_valid, exp_fe, exp_ovr);
                  if (framing_error === 1'b1) fe_count++;
               end
            end
         end
         begin
            tick(3);
            chk("reset", 8'h00, 1'b0, 1'b0, 1'b0);
            mon_en = 1'b1;
            rst    = 1'b0;
            tick(5);

            for (int i = 0; i < 8; i++) begin
               data_out_ready = tbl[i].rdy;
               run_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].stop, tbl[i].e_data,
                         tbl[i].e_valid, tbl[i].e_fe, tbl[i].e_ovr);
               serial_in = 1'b1;
               if (tbl[i].drain) begin
                  data_out_ready = 1'b1;
                  tick(1);
                  data_out_ready = 1'b0;
                  chk($sformatf("vec%0d_drain", i), tbl[i].e_data, 1'b0, 1'b0, 1'b0);
               end
               tick(tbl[i].gap);
            end
            data_out_ready = 1'b0;
            tick(3);

            // Short low pulse must be rejected as a false start
            f0 = fe_count;
            serial_in = 1'b0;
            tick(3);
            serial_in = 1'b1;
            tick(30);
            chk("glitch_idle", 8'h80, 1'b0, 1'b0, 1'b0);
            chk_int("glitch_fe_count", fe_count, f0);
            run_frame("glitch_next", 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
            serial_in = 1'b1;
            data_out_ready = 1'b1;
            tick(1);
            data_out_ready = 1'b0;
            tick(5);

            // Bad stop bit followed by a held-low line
            f0 = fe_count;
            run_frame("break_fe", 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0);
            tick(50);
            serial_in = 1'b1;
            tick(20);
            chk_int("break_fe_count", fe_count - f0, 1);
            run_frame("break_next", 8'h55, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
            serial_in = 1'b1;
            tick(5);

            // Commit in the same cycle as a handshake of the previous byte
            ce_hs = cyc + COMMIT_OFS;
            fork
               send_frame(8'h42, 1'b1, 1'b1);
               begin
                  wait_edge(ce_hs - 1, "hs_pre");
                  data_out_ready = 1'b1;
                  wait_edge(ce_hs, "hs_commit");
                  chk("hs_commit", 8'h42, 1'b1, 1'b0, 1'b0);
                  data_out_ready = 1'b0;
               end
            join
            serial_in = 1'b1;
            tick(5);

            // Reset during a frame; the aborted byte must never appear
            ab_fr = {1'b1, 8'h77, 1'b0};
            for (int b = 0; b < 5; b++) begin
               serial_in = ab_fr[b];
               tick((b == 4) ? H : N);
            end
            rst       = 1'b1;
            serial_in = 1'b1;
            tick(4);
            chk("reset_mid", 8'h00, 1'b0, 1'b0, 1'b0);
            rst = 1'b0;
            tick(150);
            chk("reset_quiet", 8'h00, 1'b0, 1'b0, 1'b0);
            run_frame("reset_next", 8'h99, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
            serial_in = 1'b1;
            tick(5);

            fork
               begin
                  for (int i = 0; i < 40; i++) begin
                     rnd_d    = 8'($urandom);
                     rnd_stop = ($urandom_range(7, 0) != 0);
                     rnd_gap  = rnd_stop ? int'($urandom_range(5, 0))
                                         : int'($urandom_range(9, 4));
                     send_frame(rnd_d, rnd_stop, 1'b1);
                     serial_in = 1'b1;
                     tick(rnd_gap);
                  end
                  rdone = 1'b1;
               end
               begin
                  while (!rdone) begin
                     @(posedge clk);
                     #1;
                     data_out_ready = 1'($urandom_range(1, 0));
                  end
               end
            join
            data_out_ready = 1'b0;
            serial_in      = 1'b1;
            tick(20);
            done = 1'b1;
         end
      join

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
